// File: rtl/ws2812_channel_tx.sv
// WS2812 single-channel frame transmitter.
// Reads LEDS*3 bytes from an external buffer (1-cycle read latency), serialises them MSB first as
// WS2812 bit cells of BIT_CYC clocks each, then holds the line low for RESET_CYC clocks to latch.
module ws2812_channel_tx #(
  parameter int unsigned LEDS       = 200,
  parameter int unsigned ADDR_WIDTH = $clog2(LEDS * 3),
  parameter int unsigned T0H_CYC    = 20,
  parameter int unsigned T1H_CYC    = 40,
  parameter int unsigned BIT_CYC    = 62,
  parameter int unsigned RESET_CYC  = 15000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  input  logic [7:0]            i_rd_data,
  output logic                  o_dout,
  output logic                  o_busy,
  output logic                  o_frame_done
);

  localparam int unsigned NumBytes = LEDS * 3;
  localparam int unsigned CycW     = $clog2(BIT_CYC);
  localparam int unsigned LatW     = (RESET_CYC > 1) ? $clog2(RESET_CYC) : 1;

  localparam logic [ADDR_WIDTH-1:0] LastByte = ADDR_WIDTH'(NumBytes - 1);
  localparam logic [ADDR_WIDTH-1:0] AddrOne  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] AddrTwo  = ADDR_WIDTH'(2);
  localparam logic [CycW-1:0]       CycOne   = CycW'(1);
  localparam logic [CycW-1:0]       CycLast  = CycW'(BIT_CYC - 1);
  localparam logic [LatW-1:0]       LatLast  = LatW'(RESET_CYC - 1);

  // Reject parameter sets that cannot produce a valid bit cell.
  if (!(T0H_CYC >= 1 && T0H_CYC < T1H_CYC && T1H_CYC < BIT_CYC && LEDS >= 1 &&
        RESET_CYC >= 1)) begin : gen_bad_params
    $error("ws2812_channel_tx: need 1 <= T0H_CYC < T1H_CYC < BIT_CYC, LEDS >= 1, RESET_CYC >= 1");
  end

  typedef enum logic [1:0] {
    StIdle,
    StPrime,
    StSend,
    StLatch
  } state_e;

  state_e                  state_q, state_d;
  logic [CycW-1:0]         cyc_q, cyc_d;     // cycle within bit cell (also PRIME step)
  logic [2:0]              bit_q, bit_d;     // bit index of current byte, 7 first
  logic [ADDR_WIDTH-1:0]   byte_q, byte_d;   // index of byte being shifted out
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LatW-1:0]         lat_q, lat_d;
  logic [7:0]              shreg_q, shreg_d;
  logic [7:0]              hold_q, hold_d;   // prefetched next byte
  logic                    dout_q, dout_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  // Next-state and next-output logic for the transmit FSM.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    addr_d  = addr_q;
    lat_d   = lat_q;
    shreg_d = shreg_q;
    hold_d  = hold_q;
    dout_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = StPrime;
          cyc_d   = '0;
          addr_d  = '0;
        end
      end

      StPrime: begin
        // Byte 0 was addressed on acceptance; it is on i_rd_data in the second cycle.
        if (cyc_q == CycOne) begin
          state_d = StSend;
          cyc_d   = '0;
          bit_d   = 3'd7;
          byte_d  = '0;
          shreg_d = i_rd_data;
          // Bit 7 of byte 0 starts now: prefetch byte 1.
          if (NumBytes > 1) begin
            addr_d = AddrOne;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end

      StSend: begin
        // dout is registered, so the line lags the counters by exactly one cycle.
        dout_d = (32'(cyc_q) < (shreg_q[7] ? T1H_CYC : T0H_CYC));
        // Address moved at the start of bit 7; data is safely valid two edges later.
        if (bit_q == 3'd7 && cyc_q == CycOne && byte_q != LastByte) begin
          hold_d = i_rd_data;
        end
        if (cyc_q == CycLast) begin
          cyc_d = '0;
          if (bit_q == 3'd0) begin
            if (byte_q == LastByte) begin
              state_d = StLatch;
              lat_d   = '0;
              addr_d  = '0;
            end else begin
              shreg_d = hold_q;
              byte_d  = byte_q + 1'b1;
              bit_d   = 3'd7;
              if ((byte_q + AddrOne) != LastByte) begin
                addr_d = byte_q + AddrTwo;
              end
            end
          end else begin
            bit_d   = bit_q - 1'b1;
            shreg_d = {shreg_q[6:0], 1'b0};
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end

      StLatch: begin
        if (lat_q == LatLast) begin
          state_d = StIdle;
          lat_d   = '0;
          done_d  = 1'b1;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  // State and output registers; synchronous reset aborts any frame immediately.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      cyc_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      addr_q  <= '0;
      lat_q   <= '0;
      shreg_q <= '0;
      hold_q  <= '0;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      addr_q  <= addr_d;
      lat_q   <= lat_d;
      shreg_q <= shreg_d;
      hold_q  <= hold_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_rd_addr    = addr_q;
  assign o_dout       = dout_q;
  assign o_busy       = busy_q;
  assign o_frame_done = done_q;

endmodule

// File: tb/tb_ws2812_channel_tx.sv
// Scoreboard bench for ws2812_channel_tx: stimulus pushes expected event times into queues,
// a negedge monitor pops them as the DUT produces rises, falls, address moves and done pulses.
module tb_ws2812_channel_tx;

  localparam int unsigned LEDS    = 2;
  localparam int unsigned T0H     = 20;
  localparam int unsigned T1H     = 40;
  localparam int unsigned BITC    = 62;
  localparam int unsigned RST_CYC = 400;
  localparam int          NB      = LEDS * 3;
  localparam int          AW      = $clog2(LEDS * 3);
  localparam int          SENDLEN = NB * 8 * BITC;
  localparam int          FRAME   = 2 + SENDLEN + RST_CYC;

  logic          clk     = 1'b0;
  logic          i_rst   = 1'b1;
  logic          i_start = 1'b0;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          dout;
  logic          busy;
  logic          done;

  ws2812_channel_tx #(
    .LEDS      (LEDS),
    .ADDR_WIDTH(AW),
    .T0H_CYC   (T0H),
    .T1H_CYC   (T1H),
    .BIT_CYC   (BITC),
    .RESET_CYC (RST_CYC)
  ) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .o_rd_addr   (rd_addr),
    .i_rd_data   (rd_data),
    .o_dout      (dout),
    .o_busy      (busy),
    .o_frame_done(done)
  );

  always #5 clk = ~clk;

  // Frame buffer with one clock of read latency.
  logic [7:0] mem [NB];
  always @(posedge clk) rd_data <= mem[rd_addr];

  int   edge_n  = 0;
  logic rst_smp = 1'b1;
  always @(posedge clk) begin
    edge_n  <= edge_n + 1;
    rst_smp <= i_rst;
  end

  // Reference model state: expected event edges and the busy window.
  int exp_rise_q [$];
  int exp_w_q    [$];
  int exp_ae_q   [$];
  int exp_av_q   [$];
  int exp_done_q [$];
  int cur_s      = 0;
  int cur_done   = 0;
  int acc_after  = 1 << 30;
  bit finish_req = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at edge %0d", name, act, exp, edge_n);
    end
  endtask

  task automatic unexpected(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got an event expected none at edge %0d", name, edge_n);
  endtask

  // Monitor: all comparisons happen here, on the falling edge.
  logic          prev_dout = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  int            rise_e    = 0;
  always @(negedge clk) begin
    if (rst_smp) begin
      chk("rst_dout", 32'(dout), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_addr", 32'(rd_addr), 0);
    end else begin
      if (dout === 1'b1 && prev_dout === 1'b0) begin
        rise_e = edge_n;
        if (exp_rise_q.size() == 0) unexpected("rise");
        else chk("rise_edge", edge_n, exp_rise_q.pop_front());
      end
      if (dout === 1'b0 && prev_dout === 1'b1) begin
        if (exp_w_q.size() == 0) unexpected("fall");
        else chk("pulse_width", edge_n - rise_e, exp_w_q.pop_front());
      end
      if (rd_addr !== prev_addr) begin
        if (exp_ae_q.size() == 0) unexpected("addr_change");
        else begin
          chk("addr_edge", edge_n, exp_ae_q.pop_front());
          chk("addr_value", 32'(rd_addr), exp_av_q.pop_front());
        end
      end
      if (done !== 1'b0) begin
        if (exp_done_q.size() == 0) unexpected("frame_done");
        else chk("done_edge", edge_n, exp_done_q.pop_front());
      end
      chk("busy", 32'(busy), 32'(edge_n >= cur_s && edge_n < cur_done));
    end
    prev_dout = dout;
    prev_addr = rd_addr;
    if (finish_req) begin
      chk("left_rises", exp_rise_q.size(), 0);
      chk("left_widths", exp_w_q.size(), 0);
      chk("left_addrs", exp_ae_q.size(), 0);
      chk("left_dones", exp_done_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  task automatic wait_edge(input int e);
    while (edge_n < e) @(negedge clk);
  endtask

  // Hold reset for n edges; smode 0: no start, 1: random start, 2: start every cycle.
  task automatic do_reset(input int n, input int smode);
    @(negedge clk);
    #1;
    i_rst = 1'b1;
    exp_rise_q.delete();
    exp_w_q.delete();
    exp_ae_q.delete();
    exp_av_q.delete();
    exp_done_q.delete();
    cur_s     = 0;
    cur_done  = 0;
    acc_after = edge_n + n;
    for (int i = 0; i < n; i++) begin
      i_start = (smode == 2) ? 1'b1 : (smode == 1) ? 1'(($urandom_range(0, 1))) : 1'b0;
      @(negedge clk);
      #1;
    end
    i_rst   = 1'b0;
    i_start = 1'b0;
  endtask

  // One-cycle start pulse; if the model says idle, load the buffer and predict the frame.
  task automatic start_frame(input bit rnd);
    int         s;
    logic [7:0] b;
    logic [7:0] pat [NB];
    pat = '{8'h80, 8'h00, 8'hFF, 8'h01, 8'h7F, 8'hA5};
    @(negedge clk);
    #1;
    s = edge_n + 1;
    if (s > acc_after) begin
      for (int k = 0; k < NB; k++) mem[k] = rnd ? 8'($urandom) : pat[k];
      for (int k = 0; k < NB; k++) begin
        b = mem[k];
        for (int i = 0; i < 8; i++) begin
          exp_rise_q.push_back(s + 3 + (k * 8 + i) * int'(BITC));
          exp_w_q.push_back(b[7-i] ? int'(T1H) : int'(T0H));
        end
        if (k < NB - 1) begin
          exp_ae_q.push_back(s + 2 + k * 8 * int'(BITC));
          exp_av_q.push_back(k + 1);
        end
      end
      exp_ae_q.push_back(s + 2 + SENDLEN);
      exp_av_q.push_back(0);
      exp_done_q.push_back(s + FRAME);
      cur_s     = s;
      cur_done  = s + FRAME;
      acc_after = cur_done;
    end
    i_start = 1'b1;
    @(negedge clk);
    #1;
    i_start = 1'b0;
  endtask

  initial begin
    int s;
    for (int k = 0; k < NB; k++) mem[k] = 8'h00;
    do_reset(3, 1);

    // Fixed pattern frame with ignored starts in SEND and in LATCH.
    start_frame(1'b0);
    s = cur_s;
    wait_edge(s + 300 + int'($urandom_range(0, 1500)));
    start_frame(1'b1);
    wait_edge(s + 2 + SENDLEN + 20 + int'($urandom_range(0, 300)));
    start_frame(1'b1);
    wait_edge(cur_done);

    // Back-to-back frame started one cycle after the done pulse.
    start_frame(1'b1);
    wait_edge(cur_done);

    // Abort in the middle of byte 1.
    wait_edge(edge_n + 3);
    start_frame(1'b1);
    wait_edge(cur_s + 2 + 8 * int'(BITC) + 3 * int'(BITC) + 10);
    do_reset(1, 0);
    wait_edge(edge_n + 4);

    // Start coincident with reset must not begin a frame.
    do_reset(1, 2);
    wait_edge(edge_n + 6);

    // Full frame after the aborts.
    start_frame(1'b1);
    wait_edge(cur_done + 5);
    finish_req = 1'b1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", edge_n);
    $fatal(1, "watchdog");
  end

endmodule
